// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and mult/div
// structural stalls, taken-branch flushes, mult/div sequencing and a stall counter.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             ID_IsMulDiv,
  input  logic             ID_UsesHiLo,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // state | meaning
  // IDLE  | mult/div unit free; a mult/div in ID may issue
  // BUSY  | operation in flight; md_cnt counts down to the final busy cycle
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int MD_CW = $clog2(MD_LATENCY);
  localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

  state_t           state, state_nxt;
  logic [MD_CW-1:0] md_cnt, md_cnt_nxt;
  logic             load_use, md_stall, stall;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  // HI/LO readers and new mult/divs wait through the final busy cycle too
  assign md_stall = (state == BUSY) && (ID_IsMulDiv || ID_UsesHiLo);
  assign stall    = load_use || md_stall;

  assign md_busy = (state == BUSY);
  assign md_done = (state == BUSY) && (md_cnt == '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    md_start   = 1'b0;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;

    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      state_nxt  = IDLE;
      md_cnt_nxt = '0;
    end else begin
      // a taken branch squashes the ID instruction, so any stall is moot
      if (EX_BranchTaken) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (stall) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end

      md_start = (state == IDLE) && ID_IsMulDiv && !stall && !EX_BranchTaken;

      case (state)
        IDLE: begin
          if (md_start) begin
            state_nxt  = BUSY;
            md_cnt_nxt = MD_LOAD;
          end
        end
        BUSY: begin
          if (md_cnt == '0) state_nxt = IDLE;
          else              md_cnt_nxt = md_cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (!PC_Write && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
